// File: rtl/mrna_iso_seq.sv
// Multi-lane protocol sequencer for the mRNA isolation bank: load, lyse, mix, separate, collect,
// and an optional flush step enabled by defining MRNA_FLUSH_EN.
module mrna_iso_seq #(
  parameter int CHANNELS      = 6,
  parameter int CNT_W         = 16,
  parameter int FILL_TICKS    = 64,
  parameter int PHASE_TICKS   = 8,
  parameter int MIX_CYCLES    = 16,
  parameter int SEP_TICKS     = 128,
  parameter int COLLECT_TICKS = 32,
  parameter int FLUSH_TICKS   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [CHANNELS-1:0]      ch_mask,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic                     aborted,
  output logic [3:0]               state_o,
  output logic [13*CHANNELS-1:0]   ctrl_out,
  output logic [13*CHANNELS-1:0]   flush_out
);

  // A zero duration still occupies one cycle.
  localparam int FILL_T    = (FILL_TICKS    == 0) ? 1 : FILL_TICKS;
  localparam int PHASE_T   = (PHASE_TICKS   == 0) ? 1 : PHASE_TICKS;
  localparam int MIX_T     = (MIX_CYCLES    == 0) ? 1 : MIX_CYCLES;
  localparam int SEP_T     = (SEP_TICKS     == 0) ? 1 : SEP_TICKS;
  localparam int COLLECT_T = (COLLECT_TICKS == 0) ? 1 : COLLECT_TICKS;
  localparam int FLUSH_T   = (FLUSH_TICKS   == 0) ? 1 : FLUSH_TICKS;

  localparam int B_COLLECT   = 0;
  localparam int B_LYSIS_IN  = 1;
  localparam int B_LYSIS_OUT = 2;
  localparam int B_PUSH      = 3;
  localparam int B_PUMP1     = 4;
  localparam int B_PUMP2     = 5;
  localparam int B_PUMP3     = 6;
  localparam int B_SEP       = 7;
  localparam int B_SIEVE     = 8;
  localparam int B_WASTE     = 9;
  localparam int B_BEADS     = 10;
  localparam int B_CELLS_IN  = 11;
  localparam int B_CELLS_OUT = 12;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_LOAD_CELLS = 4'd1,
    S_LOAD_BEADS = 4'd2,
    S_LYSIS      = 4'd3,
    S_MIX        = 4'd4,
    S_SEPARATE   = 4'd5,
    S_COLLECT    = 4'd6,
    S_FLUSH      = 4'd7,
    S_DONE       = 4'd8
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [CNT_W-1:0]         ptick_q, ptick_d;
  logic [CNT_W-1:0]         cyc_q, cyc_d;
  logic [2:0]               phase_q, phase_d;
  logic [CHANNELS-1:0]      mask_q, mask_d;
  logic [13*CHANNELS-1:0]   ctrl_q, ctrl_d;
  logic [13*CHANNELS-1:0]   flush_q, flush_d;
  logic                     done_q, done_d;
  logic                     aborted_q, aborted_d;
  logic                     at_end;
  logic                     mix_end;
  logic [12:0]              pat;

  function automatic logic [CNT_W-1:0] dwell_last(state_t s);
    logic [CNT_W-1:0] r;
    r = '0;
    case (s)
      S_LOAD_CELLS, S_LOAD_BEADS, S_LYSIS: r = CNT_W'(FILL_T - 1);
      S_SEPARATE:                          r = CNT_W'(SEP_T - 1);
      S_COLLECT:                           r = CNT_W'(COLLECT_T - 1);
      S_FLUSH:                             r = CNT_W'(FLUSH_T - 1);
      default:                             r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [12:0] lane_pattern(state_t s, logic [2:0] ph);
    logic [12:0] p;
    p = '0;
    case (s)
      S_LOAD_CELLS: begin p[B_CELLS_IN] = 1'b1; p[B_CELLS_OUT] = 1'b1; end
      S_LOAD_BEADS: begin p[B_BEADS] = 1'b1; p[B_SIEVE] = 1'b1; end
      S_LYSIS:      begin p[B_LYSIS_IN] = 1'b1; p[B_LYSIS_OUT] = 1'b1; end
      S_MIX: begin
        p[B_SEP] = 1'b1;
        // Peristaltic sequence {pump1,pump2,pump3}: 110 010 011 001 101 100.
        case (ph)
          3'd0:    begin p[B_PUMP1] = 1'b1; p[B_PUMP2] = 1'b1; end
          3'd1:    p[B_PUMP2] = 1'b1;
          3'd2:    begin p[B_PUMP2] = 1'b1; p[B_PUMP3] = 1'b1; end
          3'd3:    p[B_PUMP3] = 1'b1;
          3'd4:    begin p[B_PUMP1] = 1'b1; p[B_PUMP3] = 1'b1; end
          default: p[B_PUMP1] = 1'b1;
        endcase
      end
      S_SEPARATE:   begin p[B_SIEVE] = 1'b1; p[B_WASTE] = 1'b1; end
      S_COLLECT:    begin p[B_PUSH] = 1'b1; p[B_COLLECT] = 1'b1; end
      default:      p = '0;
    endcase
    return p;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    ptick_d   = ptick_q;
    cyc_d     = cyc_q;
    phase_d   = phase_q;
    mask_d    = mask_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    ctrl_d    = '0;
    flush_d   = '0;
    pat       = '0;
    at_end    = (cnt_q == dwell_last(state_q));
    mix_end   = (phase_q == 3'd5) && (ptick_q == CNT_W'(PHASE_T - 1)) &&
                (cyc_q == CNT_W'(MIX_T - 1));

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start && (|ch_mask)) begin
          state_d = S_LOAD_CELLS;
          mask_d  = ch_mask;
        end
      end
      S_LOAD_CELLS: if (at_end) state_d = S_LOAD_BEADS;
      S_LOAD_BEADS: if (at_end) state_d = S_LYSIS;
      S_LYSIS:      if (at_end) state_d = S_MIX;
      S_MIX: begin
        cnt_d = '0;
        if (ptick_q == CNT_W'(PHASE_T - 1)) begin
          ptick_d = '0;
          if (phase_q == 3'd5) begin
            phase_d = 3'd0;
            cyc_d   = cyc_q + CNT_W'(1);
          end else begin
            phase_d = phase_q + 3'd1;
          end
        end else begin
          ptick_d = ptick_q + CNT_W'(1);
        end
        if (mix_end) state_d = S_SEPARATE;
      end
      S_SEPARATE:   if (at_end) state_d = S_COLLECT;
      S_COLLECT: begin
`ifdef MRNA_FLUSH_EN
        if (at_end) state_d = S_FLUSH;
`else
        if (at_end) state_d = S_DONE;
`endif
      end
      S_FLUSH:      if (at_end) state_d = S_DONE;
      S_DONE:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase

    // Every state starts its dwell and pump sequence from zero.
    if (state_d != state_q) begin
      cnt_d   = '0;
      ptick_d = '0;
      cyc_d   = '0;
      phase_d = '0;
    end

    if (abort && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      ptick_d   = '0;
      cyc_d     = '0;
      phase_d   = '0;
      aborted_d = 1'b1;
    end

    // Outputs are decoded from the next state so they move with state_o.
    done_d = (state_d == S_DONE);
    pat    = lane_pattern(state_d, phase_d);
    for (int c = 0; c < CHANNELS; c++) begin
      ctrl_d[c*13 +: 13] = mask_d[c] ? pat : 13'd0;
`ifdef MRNA_FLUSH_EN
      flush_d[c*13 +: 13] = (mask_d[c] && (state_d == S_FLUSH)) ? 13'h1FFF : 13'd0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ptick_q   <= '0;
      cyc_q     <= '0;
      phase_q   <= '0;
      mask_q    <= '0;
      ctrl_q    <= '0;
      flush_q   <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptick_q   <= ptick_d;
      cyc_q     <= cyc_d;
      phase_q   <= phase_d;
      mask_q    <= mask_d;
      ctrl_q    <= ctrl_d;
      flush_q   <= flush_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign state_o   = state_q;
  assign ctrl_out  = ctrl_q;
  assign flush_out = flush_q;

endmodule

// File: tb/tb_mrna_iso_seq.sv
// Randomized bench for mrna_iso_seq: a timeline model expands each accepted run into its
// per-cycle expected outputs; a monitor compares DUT outputs against that queue every cycle.
module tb_mrna_iso_seq;

  localparam int CH    = 6;
  localparam int FILL  = 4;
  localparam int PHASE = 2;
  localparam int MIXC  = 2;
  localparam int SEP   = 3;
  localparam int COLL  = 2;
  localparam int FLT   = 3;
  localparam int LW    = 13 * CH;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CH-1:0] ch_mask = '0;
  logic          busy, done, aborted;
  logic [3:0]    state_o;
  logic [LW-1:0] ctrl_out, flush_out;

  always #5 clk = ~clk;

  mrna_iso_seq #(
    .CHANNELS(CH), .CNT_W(16), .FILL_TICKS(FILL), .PHASE_TICKS(PHASE),
    .MIX_CYCLES(MIXC), .SEP_TICKS(SEP), .COLLECT_TICKS(COLL), .FLUSH_TICKS(FLT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .ch_mask(ch_mask), .abort(abort),
    .busy(busy), .done(done), .aborted(aborted), .state_o(state_o),
    .ctrl_out(ctrl_out), .flush_out(flush_out)
  );

  typedef struct packed {
    logic [3:0]    st;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [LW-1:0] ctrl;
    logic [LW-1:0] flush;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  typedef struct packed {
    logic [3:0]  st;
    logic [12:0] pat;
  } step_t;

  logic [EXP_W-1:0] exp_q[$];
  step_t            run_q[$];
  logic [CH-1:0]    mask_m = '0;
  logic [2:0]       pump_tbl[6] = '{3'b110, 3'b010, 3'b011, 3'b001, 3'b101, 3'b100};
  int checks = 0, failures = 0, cyc = 0, done_seen = 0, done_exp = 0;

  function automatic logic [12:0] b(input int n);
    return 13'd1 << n;
  endfunction

  function automatic void add_steps(input logic [3:0] st, input logic [12:0] pat, input int n);
    step_t s;
    s.st  = st;
    s.pat = pat;
    for (int i = 0; i < ((n == 0) ? 1 : n); i++) run_q.push_back(s);
  endfunction

  // Lay out a whole protocol run as a list of per-cycle (state, lane pattern) entries.
  function automatic void build_run();
    logic [2:0] p;
    add_steps(4'd1, b(11) | b(12), FILL);
    add_steps(4'd2, b(10) | b(8), FILL);
    add_steps(4'd3, b(1) | b(2), FILL);
    for (int cy = 0; cy < MIXC; cy++)
      for (int ph = 0; ph < 6; ph++) begin
        p = pump_tbl[ph];
        add_steps(4'd4, b(7) | (p[2] ? b(4) : 13'd0) | (p[1] ? b(5) : 13'd0) |
                  (p[0] ? b(6) : 13'd0), PHASE);
      end
    add_steps(4'd5, b(8) | b(9), SEP);
    add_steps(4'd6, b(3) | b(0), COLL);
`ifdef MRNA_FLUSH_EN
    add_steps(4'd7, 13'd0, FLT);
`endif
    add_steps(4'd8, 13'd0, 1);
  endfunction

  function automatic void model_edge(input logic s, input logic [CH-1:0] m, input logic a,
                                     input logic r);
    exp_t e;
    logic ab;
    ab = 1'b0;
    if (r) begin
      run_q.delete();
      mask_m = '0;
    end else if (run_q.size() > 0) begin
      if (a) begin
        run_q.delete();
        ab = 1'b1;
      end else begin
        void'(run_q.pop_front());
      end
    end else if (s && (|m)) begin
      mask_m = m;
      build_run();
    end
    e = '0;
    e.aborted = ab;
    if (run_q.size() > 0) begin
      e.st   = run_q[0].st;
      e.busy = 1'b1;
      e.done = (run_q[0].st == 4'd8);
      for (int c = 0; c < CH; c++) begin
        if (mask_m[c]) begin
          e.ctrl[c*13 +: 13] = run_q[0].pat;
          if (run_q[0].st == 4'd7) e.flush[c*13 +: 13] = 13'h1FFF;
        end
      end
    end
    if (e.done) done_exp++;
    exp_q.push_back(e);
  endfunction

  task automatic step(input logic s, input logic [CH-1:0] m, input logic a, input logic r);
    @(negedge clk);
    start   = s;
    ch_mask = m;
    abort   = a;
    rst     = r;
    model_edge(s, m, a, r);
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  // Play out the current run; noisy runs toggle start and ch_mask while busy.
  task automatic run_out(input int noisy, input int abort_pct, input int rst_pct);
    int n;
    logic s, a, r;
    logic [CH-1:0] m;
    n = 0;
    while (run_q.size() > 0 && n < 200) begin
      s = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      m = noisy ? CH'($urandom_range(0, 63)) : '0;
      a = (abort_pct > 0) && ($urandom_range(1, 100) <= abort_pct);
      r = (rst_pct > 0) && ($urandom_range(1, 1000) <= rst_pct);
      step(s, m, a, r);
      n++;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_t'(exp_q.pop_front());
        chk("state_o", 128'(state_o), 128'(e.st));
        chk("busy", 128'(busy), 128'(e.busy));
        chk("done", 128'(done), 128'(e.done));
        chk("aborted", 128'(aborted), 128'(e.aborted));
        chk("ctrl_out", 128'(ctrl_out), 128'(e.ctrl));
        chk("flush_out", 128'(flush_out), 128'(e.flush));
        if (done) done_seen++;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    repeat (3) step(1'b0, '0, 1'b0, 1'b1);
    repeat (2) step(1'b0, '0, 1'b0, 1'b0);
    // Clean run on lanes 0 and 2.
    step(1'b1, 6'b000101, 1'b0, 1'b0);
    run_out(0, 0, 0);
    step(1'b0, '0, 1'b0, 1'b0);
    // Empty mask is ignored; abort alone in IDLE does nothing.
    step(1'b1, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    // Abort in the fifth MIX cycle, with start/mask noise before it.
    step(1'b1, 6'b000101, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'($urandom_range(0, 1)), CH'($urandom_range(0, 63)), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    // Next start accepted normally; noise must not change timing or gating.
    step(1'b1, 6'b101001, 1'b0, 1'b0);
    run_out(1, 0, 0);
    // Start together with abort in IDLE: start wins.
    step(1'b1, 6'b010010, 1'b1, 1'b0);
    run_out(1, 0, 0);
    // Random runs with occasional abort and reset.
    for (int r = 0; r < 8; r++) begin
      repeat ($urandom_range(0, 3)) step(1'b0, CH'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 1'b0);
      step(1'b1, CH'($urandom_range(1, 63)), 1'($urandom_range(0, 1)), 1'b0);
      run_out(1, 2, 10);
      step(1'b0, '0, 1'b0, 1'b0);
    end
    repeat (2) step(1'b0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("done_pulse_count", 128'(done_seen), 128'(done_exp));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
